// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, 1-bit/cycle shifts, shift-add MUL and
// restoring DIVU/REMU, behind a start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted only on a rising edge where busy==0; done is high for
  // exactly one cycle and result/flags are valid from that cycle until the next done.

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   x_q, x_d;     // shift value / multiplicand / dividend->quotient
  logic [WIDTH-1:0]   y_q, y_d;     // multiplier / divisor
  logic [WIDTH-1:0]   acc_q, acc_d; // product accumulator / partial remainder
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               dbz_q, dbz_d;
  logic               ill_q, ill_d;

  logic [WIDTH-1:0]   shift_c;
  logic [WIDTH-1:0]   mul_acc_c;
  logic [WIDTH:0]     div_cat_c;
  logic               div_ge_c;
  logic [WIDTH-1:0]   div_rem_c;
  logic [WIDTH-1:0]   div_quo_c;

  logic               fin_c;
  logic [WIDTH-1:0]   res_c;
  logic               ill_c;
  logic               dbz_c;

  // One iteration of each multi-cycle datapath, driven from the working registers.
  always_comb begin
    shift_c = x_q;
    case (op_q)
      OP_SLL:  shift_c = x_q << 1;
      OP_SRL:  shift_c = x_q >> 1;
      default: shift_c = {x_q[WIDTH-1], x_q[WIDTH-1:1]};
    endcase
    mul_acc_c = acc_q + (y_q[0] ? x_q : '0);
    div_cat_c = {acc_q, x_q[WIDTH-1]};
    div_ge_c  = div_cat_c >= {1'b0, y_q};
    div_rem_c = div_ge_c ? WIDTH'(div_cat_c - {1'b0, y_q}) : div_cat_c[WIDTH-1:0];
    div_quo_c = {x_q[WIDTH-2:0], div_ge_c};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    fin_c    = 1'b0;
    res_c    = '0;
    ill_c    = 1'b0;
    dbz_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = opcode;
          x_d   = a;
          y_d   = b;
          acc_d = '0;
          case (opcode)
            OP_ADD: begin fin_c = 1'b1; res_c = a + b; end
            OP_SUB: begin fin_c = 1'b1; res_c = a - b; end
            OP_AND: begin fin_c = 1'b1; res_c = a & b; end
            OP_OR:  begin fin_c = 1'b1; res_c = a | b; end
            OP_XOR: begin fin_c = 1'b1; res_c = a ^ b; end
            OP_LUI: begin fin_c = 1'b1; res_c = a;     end
            OP_SLL, OP_SRL, OP_SRA: begin
              if (b[SHAMT_W-1:0] == '0) begin
                fin_c = 1'b1;
                res_c = a;
              end else begin
                cnt_d   = CNT_W'(b[SHAMT_W-1:0]);
                state_d = RUN;
              end
            end
            OP_MUL, OP_DIVU, OP_REMU: begin
              cnt_d   = CNT_W'(WIDTH);
              state_d = RUN;
            end
            default: begin fin_c = 1'b1; ill_c = 1'b1; end
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        case (op_q)
          OP_MUL: begin
            acc_d = mul_acc_c;
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
            res_c = mul_acc_c;
          end
          OP_DIVU, OP_REMU: begin
            acc_d = div_rem_c;
            x_d   = div_quo_c;
            res_c = (op_q == OP_DIVU) ? div_quo_c : div_rem_c;
          end
          default: begin
            x_d   = shift_c;
            res_c = shift_c;
          end
        endcase
        if (cnt_q == CNT_W'(1)) begin
          fin_c = 1'b1;
          dbz_c = ((op_q == OP_DIVU) || (op_q == OP_REMU)) && (y_q == '0);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin_c) begin
      state_d  = DONE;
      result_d = res_c;
      zero_d   = (res_c == '0);
      dbz_d    = dbz_c;
      ill_d    = ill_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;
  assign state_dbg   = state_q;

endmodule
